// File: rtl/gs_frame_sequencer.sv
// Frame sequencer for the grayscale LED driver chain.
// Optional row blanking state: define GS_SM_DEADTIME_EN.
module gs_frame_sequencer #(
  parameter int NB_ANGLES         = 128,
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int NB_ROWS           = 4,
  parameter int NB_COLORS         = 3,
  parameter int GS_BITS           = 16,
  parameter int WRTGS_LEN         = 1,
  parameter int LATGS_LEN         = 3,
  parameter int DEADTIME_LEN      = 2,
  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES),
  localparam int LED_W = $clog2(NB_LEDS_PER_GROUP),
  localparam int COL_W = (NB_COLORS > 1) ? $clog2(NB_COLORS) : 1,
  localparam int BIT_W = $clog2(GS_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SCLK,
  input  logic [ANGLE_WIDTH-1:0] angle,
  output logic [NB_ROWS-1:0]     row_en,
  output logic [LED_W-1:0]       led,
  output logic [COL_W-1:0]       color,
  output logic [BIT_W-1:0]       bit_sel,
  output logic                   LAT,
  output logic [ANGLE_WIDTH-1:0] cur_angle,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int ROW_W  = (NB_ROWS > 1) ? $clog2(NB_ROWS) : 1;
  localparam int DEAD_W = (DEADTIME_LEN > 1) ? $clog2(DEADTIME_LEN) : 1;

  localparam logic [LED_W-1:0] LED_MAX = LED_W'(NB_LEDS_PER_GROUP - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(NB_COLORS - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(GS_BITS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NB_ROWS - 1);
  localparam logic [BIT_W:0]   WRTGS_T = (BIT_W+1)'(WRTGS_LEN);
  localparam logic [BIT_W:0]   LATGS_T = (BIT_W+1)'(LATGS_LEN);
  localparam logic [DEAD_W-1:0] DEAD_LD = DEAD_W'(DEADTIME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 sclk_q;
  logic                 fall;
  logic [ROW_W-1:0]     row_q;
  logic [DEAD_W-1:0]    dcnt;
  logic [ANGLE_WIDTH-1:0] last_angle;
  logic                 pending;
  logic                 eor;
  logic                 last_row;
  logic                 angle_chg;

  assign fall      = sclk_q & ~SCLK;
  assign eor       = (led == '0) && (color == '0) && (bit_sel == '0);
  assign last_row  = (row_q == ROW_MAX);
  assign angle_chg = (angle != last_angle);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: every transition waits for an SCLK fall
  always_comb begin
    state_d = state_q;
    if (fall) begin
      unique case (state_q)
        IDLE:  if (pending) state_d = SHIFT;
        SHIFT: begin
          if (eor) begin
            if (last_row) state_d = IDLE;
`ifdef GS_SM_DEADTIME_EN
            else          state_d = DEAD;
`else
            else          state_d = SHIFT;
`endif
          end
        end
        DEAD:  if (dcnt == '0) state_d = SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and counters
  always_comb begin
    row_en = '0;
    LAT    = 1'b0;
    busy   = (state_q != IDLE);
    if (state_q == SHIFT) begin
      row_en = NB_ROWS'(1) << row_q;
      LAT = (color == '0) &&
            ({1'b0, bit_sel} <
             ((led == '0) ? LATGS_T : WRTGS_T));
    end
  end

  // Counters, angle tracking and frame handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q     <= 1'b0;
      row_q      <= '0;
      led        <= '0;
      color      <= '0;
      bit_sel    <= '0;
      dcnt       <= '0;
      cur_angle  <= '0;
      last_angle <= '0;
      pending    <= 1'b1;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sclk_q     <= SCLK;
      frame_done <= 1'b0;
      if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (pending) begin
              cur_angle <= last_angle;
              pending   <= 1'b0;
              row_q     <= '0;
              led       <= LED_MAX;
              color     <= COL_MAX;
              bit_sel   <= BIT_MAX;
            end
          end
          SHIFT: begin
            // All-zero counters wrap to their maxima: the reload for the next row
            bit_sel <= (bit_sel == '0) ? BIT_MAX : bit_sel - 1'b1;
            if (bit_sel == '0)
              color <= (color == '0) ? COL_MAX : color - 1'b1;
            if (bit_sel == '0 && color == '0)
              led <= led - 1'b1;
            if (eor) begin
              if (last_row) begin
                frame_done <= 1'b1;
                led        <= '0;
                color      <= '0;
                bit_sel    <= '0;
              end else begin
`ifdef GS_SM_DEADTIME_EN
                dcnt  <= DEAD_LD;
`else
                row_q <= row_q + 1'b1;
`endif
              end
            end
          end
          DEAD: begin
            if (dcnt == '0) row_q <= row_q + 1'b1;
            else            dcnt  <= dcnt - 1'b1;
          end
          default: ;
        endcase
      end
      // A new angle outranks the pending clear of a frame start
      if (angle_chg) begin
        last_angle <= angle;
        pending    <= 1'b1;
        if (pending && busy) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gs_frame_sequencer.sv
// Bench for gs_frame_sequencer, small geometry.
// Expected SCLK-period tuples queued per frame.
module tb_gs_frame_sequencer;

  logic       clk = 1'b0;
  logic       SCLK = 1'b0;
  logic       rst;
  logic [6:0] angle;
  logic [1:0] row_en;
  logic [1:0] led;
  logic [1:0] color;
  logic [1:0] bit_sel;
  logic       LAT;
  logic [6:0] cur_angle;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  gs_frame_sequencer #(
    .NB_ANGLES(128),
    .NB_LEDS_PER_GROUP(4),
    .NB_ROWS(2),
    .NB_COLORS(3),
    .GS_BITS(4),
    .WRTGS_LEN(1),
    .LATGS_LEN(3),
    .DEADTIME_LEN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SCLK(SCLK),
    .angle(angle),
    .row_en(row_en),
    .led(led),
    .color(color),
    .bit_sel(bit_sel),
    .LAT(LAT),
    .cur_angle(cur_angle),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #10 clk = ~clk;
  always #100 SCLK = ~SCLK;

`ifdef GS_SM_DEADTIME_EN
  localparam int NDEAD = 2;
`else
  localparam int NDEAD = 0;
`endif
  localparam int FRAME_N = 96 + NDEAD + 1;

  int vectors = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd_wide = 0;
  logic fd_prev = 1'b0;

  // tuple: row_en, led, color, bit, LAT, busy, cur_angle
  logic [33:0] q[$];

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (frame_done && fd_prev) fd_wide++;
    fd_prev = frame_done;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk(
      input logic [16:0] v, input logic [16:0] m);
    return {v, m};
  endfunction

  task automatic push_frame(input logic [6:0] a);
    logic [1:0] re;
    logic       lt;
    for (int r = 0; r < 2; r++) begin
      re = (r == 0) ? 2'b01 : 2'b10;
      for (int l = 3; l >= 0; l--)
        for (int c = 2; c >= 0; c--)
          for (int b = 3; b >= 0; b--) begin
            lt = (c == 0) && (b < ((l == 0) ? 3 : 1));
            q.push_back(mk({re, 2'(l), 2'(c), 2'(b),
                            lt, 1'b1, a}, 17'h1ffff));
          end
      if (r == 0)
        for (int d = 0; d < NDEAD; d++)
          q.push_back(mk({2'b00, 6'h0, 1'b0, 1'b1, a},
                         {2'b11, 6'h0, 1'b1, 1'b1, 7'h7f}));
    end
    q.push_back(mk({2'b00, 6'h0, 1'b0, 1'b0, 7'h0},
                   {2'b11, 6'h0, 1'b1, 1'b1, 7'h0}));
  endtask

  task automatic run(input int n);
    logic [33:0] e;
    logic [16:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge SCLK);
      #1;
      if (q.size() == 0) begin
        chk("queue_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        o = {row_en, led, color, bit_sel, LAT, busy,
             cur_angle};
        chk("period", 32'(o & e[16:0]),
            32'(e[33:17] & e[16:0]));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_row_en"}, 32'(row_en), 32'd0);
    chk({tag, "_cnt"}, 32'({led, color, bit_sel}), 32'd0);
    chk({tag, "_lat"}, 32'(LAT), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_ang"}, 32'(cur_angle), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    angle = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge SCLK);
    #1 rst = 1'b0;

    push_frame(7'd0);
    run(10);
    angle = 7'd5;
    run(FRAME_N - 10);
    chk("f1_done_cnt", 32'(fd_cnt), 32'd1);
    chk("f1_overrun", 32'(overrun), 32'd0);

    push_frame(7'd5);
    run(10);
    angle = 7'd6;
    run(10);
    angle = 7'd7;
    run(FRAME_N - 20);
    chk("f2_done_cnt", 32'(fd_cnt), 32'd2);
    chk("f2_overrun", 32'(overrun), 32'd1);
    chk("done_width", 32'(fd_wide), 32'd0);

    push_frame(7'd7);
    run(20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    q.delete();
    angle = 7'd0;
    repeat (2) @(posedge clk);
    @(posedge SCLK);
    #1 rst = 1'b0;
    push_frame(7'd0);
    run(12);
    chk("restart_overrun", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
